// File: rtl/dds_phase_gen_if.sv
// rtl/dds_phase_gen_if.sv - control and sample bus between sampling controller and DDS phase generator
interface dds_phase_gen_if #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 8
);
    logic               Ready;
    logic               Enable;
    logic [2:0]         Mode;
    logic [PHASE_W-1:0] Ftw;
    logic [1:0]         WaveSel;
    logic [OUT_W-1:0]   Sample;
    logic               SampleValid;
    logic               Running;
    logic               ModeChg;

    // Controller side: drives start/advance/tuning, observes samples.
    modport master (
        output Ready, Enable, Mode, Ftw, WaveSel,
        input  Sample, SampleValid, Running, ModeChg
    );

    // Phase generator side.
    modport slave (
        input  Ready, Enable, Mode, Ftw, WaveSel,
        output Sample, SampleValid, Running, ModeChg
    );
endinterface

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - phase accumulator and registered waveform generator for the DDS output stage
module dds_phase_gen #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 8
) (
    input  logic          Fg_clk,
    input  logic          Resetn,
    dds_phase_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw_q;
    logic               r_ftw_pend;
    logic [2:0]         r_mode_q;
    logic [OUT_W-1:0]   r_sample;
    logic               r_sample_valid;
    logic               r_mode_chg;

    logic               w_running;
    logic               w_do_prime;
    logic               w_do_modechg;
    logic               w_do_step;

    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W-1:0] w_acc_next;
    logic               w_carry;
    logic [OUT_W:0]     w_u;
    logic [OUT_W-1:0]   w_t;
    logic [OUT_W-1:0]   w_wave;

    // State register; asynchronous reset forces IDLE so a fresh Ready is needed.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle action select; in RUN, Ready beats a Mode change, which beats Enable.
    always_comb begin
        w_state_next = r_state;
        w_running    = 1'b0;
        w_do_prime   = 1'b0;
        w_do_modechg = 1'b0;
        w_do_step    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Ready) begin
                    w_state_next = S_PRIME;
                end
            end
            S_PRIME: begin
                w_do_prime   = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_running = 1'b1;
                if (bus.Ready) begin
                    w_state_next = S_PRIME;
                end else if (bus.Mode != r_mode_q) begin
                    w_do_modechg = 1'b1;
                end else if (bus.Enable) begin
                    w_do_step = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One-bit-wider add so the wrap (carry) is visible for the deferred tuning-word load.
    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, r_ftw_q};
        w_acc_next = w_sum[PHASE_W-1:0];
        w_carry    = w_sum[PHASE_W];
        w_u        = w_acc_next[PHASE_W-1 -: OUT_W+1];
        w_t        = w_acc_next[PHASE_W-1 -: OUT_W];
    end

    // Waveform shaping from the post-step phase so the sample matches the new accumulator value.
    always_comb begin
        w_wave = '0;
        case (bus.WaveSel)
            2'd0: w_wave = w_t;
            2'd1: w_wave = w_acc_next[PHASE_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
            2'd2: w_wave = w_u[OUT_W] ? ~w_u[OUT_W-1:0] : w_u[OUT_W-1:0];
            2'd3: w_wave = ~w_t;
            default: w_wave = '0;
        endcase
    end

    // Datapath: prime, mode-change phase reset, and stepping with tuning word held until phase wrap.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            r_acc          <= '0;
            r_ftw_q        <= '0;
            r_ftw_pend     <= 1'b0;
            r_mode_q       <= 3'd0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_mode_chg     <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_mode_chg     <= 1'b0;
            if (w_do_prime) begin
                r_acc      <= '0;
                r_ftw_q    <= bus.Ftw;
                r_ftw_pend <= 1'b0;
                r_mode_q   <= bus.Mode;
                r_sample   <= '0;
            end else if (w_running) begin
                if (bus.Ftw != r_ftw_q) begin
                    r_ftw_pend <= 1'b1;
                end
                if (w_do_modechg) begin
                    r_acc      <= '0;
                    r_mode_q   <= bus.Mode;
                    r_sample   <= '0;
                    r_mode_chg <= 1'b1;
                end else if (w_do_step) begin
                    r_acc          <= w_acc_next;
                    r_sample       <= w_wave;
                    r_sample_valid <= 1'b1;
                    // The wrapping step itself still used the old word; the new one applies next step.
                    if (w_carry && r_ftw_pend) begin
                        r_ftw_q    <= bus.Ftw;
                        r_ftw_pend <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.Sample      = r_sample;
    assign bus.SampleValid = r_sample_valid;
    assign bus.Running     = w_running;
    assign bus.ModeChg     = r_mode_chg;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - directed self-checking bench for dds_phase_gen
module tb_dds_phase_gen;
    localparam int PW = 24;
    localparam int OW = 8;

    logic Fg_clk = 1'b0;
    logic Resetn = 1'b0;
    int   tests  = 0;
    int   errors = 0;

    localparam logic [7:0] TRI_EXP [0:16] = '{
        8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'hFF,
        8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00, 8'h20};
    localparam logic [7:0] SQ_EXP [0:15] = '{
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    dds_phase_gen_if #(.PHASE_W(PW), .OUT_W(OW)) bus();

    dds_phase_gen #(.PHASE_W(PW), .OUT_W(OW)) dut (
        .Fg_clk (Fg_clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Fg_clk = ~Fg_clk;

    // Reset, then Ready pulse; returns on the negedge after the PRIME edge (state RUN).
    task automatic start_run();
        Resetn    = 1'b0;
        bus.Ready = 1'b0;
        bus.Mode  = 3'd0;
        @(negedge Fg_clk);
        Resetn    = 1'b1;
        bus.Ready = 1'b1;
        @(negedge Fg_clk);
        bus.Ready = 1'b0;
        @(negedge Fg_clk);
    endtask

    task automatic test_reset();
        bus.Ready = 1'b0; bus.Enable = 1'b1; bus.Mode = 3'd0;
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0;
        Resetn = 1'b0;
        @(negedge Fg_clk);
        tests++;
        if (bus.Sample !== 8'h00 || bus.SampleValid !== 1'b0 || bus.Running !== 1'b0 || bus.ModeChg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got S=%h V=%b R=%b M=%b want 00 0 0 0", bus.Sample, bus.SampleValid, bus.Running, bus.ModeChg);
        end
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.SampleValid !== 1'b0 || bus.Running !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignores_enable[%0d]: got V=%b R=%b want 0 0", i, bus.SampleValid, bus.Running);
            end
        end
    endtask

    task automatic test_saw();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Mode = 3'd0; bus.Enable = 1'b1;
        Resetn = 1'b0; bus.Ready = 1'b0;
        @(negedge Fg_clk);
        Resetn = 1'b1; bus.Ready = 1'b1;
        @(negedge Fg_clk);
        tests++;
        if (bus.Running !== 1'b0) begin
            errors++; $display("FAIL saw_prime_running: got %b want 0", bus.Running);
        end
        bus.Ready = 1'b0;
        @(negedge Fg_clk);
        tests++;
        if (bus.Running !== 1'b1 || bus.SampleValid !== 1'b0) begin
            errors++; $display("FAIL saw_run_entry: got R=%b V=%b want 1 0", bus.Running, bus.SampleValid);
        end
        for (int i = 1; i <= 17; i++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== 8'(i * 16) || bus.SampleValid !== 1'b1) begin
                errors++; $display("FAIL saw_step[%0d]: got S=%h V=%b want %h 1", i, bus.Sample, bus.SampleValid, 8'(i * 16));
            end
        end
    endtask

    task automatic test_triangle_square();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd2; bus.Enable = 1'b1;
        start_run();
        for (int k = 0; k <= 16; k++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== TRI_EXP[k] || bus.SampleValid !== 1'b1) begin
                errors++; $display("FAIL tri_step[%0d]: got S=%h V=%b want %h 1", k, bus.Sample, bus.SampleValid, TRI_EXP[k]);
            end
        end
        bus.WaveSel = 2'd1;
        start_run();
        for (int k = 0; k <= 15; k++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== SQ_EXP[k] || bus.SampleValid !== 1'b1) begin
                errors++; $display("FAIL sq_step[%0d]: got S=%h V=%b want %h 1", k, bus.Sample, bus.SampleValid, SQ_EXP[k]);
            end
        end
    endtask

    task automatic test_wavesel_switch();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b1;
        start_run();
        for (int k = 1; k <= 2; k++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== 8'(k * 16)) begin
                errors++; $display("FAIL ws_saw[%0d]: got %h want %h", k, bus.Sample, 8'(k * 16));
            end
        end
        bus.WaveSel = 2'd3;
        @(negedge Fg_clk);
        tests++;
        if (bus.Sample !== 8'hCF) begin
            errors++; $display("FAIL ws_inv_first: got %h want cf", bus.Sample);
        end
        @(negedge Fg_clk);
        tests++;
        if (bus.Sample !== 8'hBF) begin
            errors++; $display("FAIL ws_inv_second: got %h want bf", bus.Sample);
        end
    endtask

    task automatic test_ftw_glitch();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b1;
        start_run();
        for (int k = 1; k <= 3; k++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== 8'(k * 16)) begin
                errors++; $display("FAIL ftw_pre[%0d]: got %h want %h", k, bus.Sample, 8'(k * 16));
            end
        end
        bus.Ftw = 24'h200000;
        for (int k = 4; k <= 16; k++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== 8'(k * 16) || bus.SampleValid !== 1'b1) begin
                errors++; $display("FAIL ftw_hold[%0d]: got S=%h V=%b want %h 1", k, bus.Sample, bus.SampleValid, 8'(k * 16));
            end
        end
        for (int j = 1; j <= 3; j++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.Sample !== 8'(j * 32)) begin
                errors++; $display("FAIL ftw_new[%0d]: got %h want %h", j, bus.Sample, 8'(j * 32));
            end
        end
    endtask

    task automatic test_mode_change();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b1;
        start_run();
        repeat (2) @(negedge Fg_clk);
        tests++;
        if (bus.Sample !== 8'h20) begin
            errors++; $display("FAIL mode_pre: got %h want 20", bus.Sample);
        end
        bus.Mode = 3'd2;
        @(negedge Fg_clk);
        tests++;
        if (bus.ModeChg !== 1'b1 || bus.SampleValid !== 1'b0 || bus.Sample !== 8'h00) begin
            errors++; $display("FAIL mode_chg: got M=%b V=%b S=%h want 1 0 00", bus.ModeChg, bus.SampleValid, bus.Sample);
        end
        @(negedge Fg_clk);
        tests++;
        if (bus.ModeChg !== 1'b0 || bus.SampleValid !== 1'b1 || bus.Sample !== 8'h10) begin
            errors++; $display("FAIL mode_after: got M=%b V=%b S=%h want 0 1 10", bus.ModeChg, bus.SampleValid, bus.Sample);
        end
    endtask

    task automatic test_restart();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b1;
        start_run();
        repeat (3) @(negedge Fg_clk);
        bus.Ready = 1'b1;
        @(negedge Fg_clk);
        tests++;
        if (bus.Running !== 1'b0 || bus.SampleValid !== 1'b0 || bus.Sample !== 8'h30) begin
            errors++; $display("FAIL restart_ready: got R=%b V=%b S=%h want 0 0 30", bus.Running, bus.SampleValid, bus.Sample);
        end
        bus.Ready = 1'b0;
        @(negedge Fg_clk);
        tests++;
        if (bus.Running !== 1'b1 || bus.SampleValid !== 1'b0 || bus.Sample !== 8'h00) begin
            errors++; $display("FAIL restart_prime: got R=%b V=%b S=%h want 1 0 00", bus.Running, bus.SampleValid, bus.Sample);
        end
        @(negedge Fg_clk);
        tests++;
        if (bus.SampleValid !== 1'b1 || bus.Sample !== 8'h10) begin
            errors++; $display("FAIL restart_first: got V=%b S=%h want 1 10", bus.SampleValid, bus.Sample);
        end
    endtask

    task automatic test_reset_mid();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b1;
        start_run();
        repeat (3) @(negedge Fg_clk);
        @(posedge Fg_clk);
        #2 Resetn = 1'b0;
        #1;
        tests++;
        if (bus.Sample !== 8'h00 || bus.SampleValid !== 1'b0 || bus.Running !== 1'b0 || bus.ModeChg !== 1'b0) begin
            errors++; $display("FAIL reset_async: got S=%h V=%b R=%b M=%b want 00 0 0 0", bus.Sample, bus.SampleValid, bus.Running, bus.ModeChg);
        end
        @(negedge Fg_clk);
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.SampleValid !== 1'b0 || bus.Running !== 1'b0) begin
                errors++; $display("FAIL reset_needs_ready[%0d]: got V=%b R=%b want 0 0", i, bus.SampleValid, bus.Running);
            end
        end
    endtask

    task automatic test_enable_gaps();
        bus.Ftw = 24'h100000; bus.WaveSel = 2'd0; bus.Enable = 1'b0;
        start_run();
        for (int n = 1; n <= 4; n++) begin
            bus.Enable = 1'b1;
            @(negedge Fg_clk);
            bus.Enable = 1'b0;
            tests++;
            if (bus.SampleValid !== 1'b1 || bus.Sample !== 8'(n * 16)) begin
                errors++; $display("FAIL gap_step[%0d]: got V=%b S=%h want 1 %h", n, bus.SampleValid, bus.Sample, 8'(n * 16));
            end
            for (int i = 0; i < 9; i++) begin
                @(negedge Fg_clk);
                tests++;
                if (bus.SampleValid !== 1'b0) begin
                    errors++; $display("FAIL gap_idle[%0d.%0d]: got V=%b want 0", n, i, bus.SampleValid);
                end
            end
        end
        bus.Ftw = 24'h000000; bus.Enable = 1'b1;
        start_run();
        for (int i = 0; i < 4; i++) begin
            @(negedge Fg_clk);
            tests++;
            if (bus.SampleValid !== 1'b1 || bus.Sample !== 8'h00) begin
                errors++; $display("FAIL ftw_zero[%0d]: got V=%b S=%h want 1 00", i, bus.SampleValid, bus.Sample);
            end
        end
    endtask

    initial begin
        bus.Ready = 1'b0; bus.Enable = 1'b0; bus.Mode = 3'd0;
        bus.Ftw = '0; bus.WaveSel = 2'd0;
        test_reset();
        test_saw();
        test_triangle_square();
        test_wavesel_switch();
        test_ftw_glitch();
        test_mode_change();
        test_restart();
        test_reset_mid();
        test_enable_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
